cnt_sequencer: RTL

CNT_SEQUENCER -- requirements
Module: cnt_sequencer

---
 rtl/cnt_sequencer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/cnt_sequencer.sv
// cnt_sequencer: command-driven 8-bit up/down counter with an IDLE/RUN/PAUSE/DONE
// sequencer, a programmable terminal limit, optional auto-reload and a
// single-cycle done pulse.
//
// Optional feature macro: CNT_SEQ_PRESCALE_EN
//   defined   -> START latches a 4-bit prescale P from cmd_data[7:4]; RUN ticks
//                occur every P+1 cycles.
//   undefined -> every RUN cycle is a tick and cmd_data[7:4] is ignored by START.
//
// An accepted command always pre-empts the RUN tick on the same edge: the
// counter neither steps nor reaches terminal on that edge. In particular a
// SET_LIMIT in RUN holds count for that one edge, so the new limit is first
// seen by the following tick compare.

module cnt_sequencer #(
  parameter logic [7:0] LIMIT_RST = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [7:0] count,
  output logic [1:0] state,
  output logic       done,
  output logic       busy
);

  // FSM state encoding (visible on the state port)
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  // Command opcodes
  localparam logic [1:0] OP_SET_LIMIT = 2'b00;
  localparam logic [1:0] OP_START     = 2'b01;
  localparam logic [1:0] OP_STOP      = 2'b10;
  localparam logic [1:0] OP_CLEAR     = 2'b11;

  // Architectural registers
  logic [7:0] limit_r;
  logic       auto_reload_r;
  logic       down_r;
  logic [7:0] count_r;
  logic [1:0] state_r;
  logic       done_r;
  logic       busy_r;
  logic       cmd_ready_r;

  // Next-state values
  logic [7:0] limit_nxt_s;
  logic       auto_reload_nxt_s;
  logic       down_nxt_s;
  logic [7:0] count_nxt_s;
  logic [1:0] state_nxt_s;
  logic       done_nxt_s;

  // Handshake and tick qualifiers
  logic       accept_s;
  logic       tick_s;
  logic       terminal_s;

`ifdef CNT_SEQ_PRESCALE_EN
  logic [3:0] prescale_r;
  logic [3:0] prescaler_r;
  logic       presc_restart_s;
  logic       prescale_load_s;
`endif

  assign accept_s = cmd_valid & cmd_ready_r;

`ifdef CNT_SEQ_PRESCALE_EN
  assign tick_s = (state_r == ST_RUN) && (prescaler_r == prescale_r);
`else
  assign tick_s = (state_r == ST_RUN);
`endif

  // Terminal value is the limit when counting up and zero when counting down
  assign terminal_s = down_r ? (count_r == 8'd0) : (count_r == limit_r);

  assign cmd_ready = cmd_ready_r;
  assign count     = count_r;
  assign state     = state_r;
  assign done      = done_r;
  assign busy      = busy_r;

  // Next-state computation: accepted command first, otherwise a RUN tick
  always_comb begin
    limit_nxt_s       = limit_r;
    auto_reload_nxt_s = auto_reload_r;
    down_nxt_s        = down_r;
    count_nxt_s       = count_r;
    state_nxt_s       = state_r;
    done_nxt_s        = 1'b0;
`ifdef CNT_SEQ_PRESCALE_EN
    presc_restart_s   = 1'b0;
    prescale_load_s   = 1'b0;
`endif
    if (accept_s) begin
      case (cmd_op)
        OP_SET_LIMIT: begin
          limit_nxt_s = cmd_data;
        end
        OP_START: begin
          if (state_r == ST_PAUSE) begin
            // Resume: operand ignored, count untouched
            state_nxt_s = ST_RUN;
          end else begin
            auto_reload_nxt_s = cmd_data[0];
            down_nxt_s        = cmd_data[1];
            count_nxt_s       = cmd_data[1] ? limit_r : 8'd0;
            state_nxt_s       = ST_RUN;
`ifdef CNT_SEQ_PRESCALE_EN
            prescale_load_s   = 1'b1;
`endif
          end
`ifdef CNT_SEQ_PRESCALE_EN
          presc_restart_s = 1'b1;
`endif
        end
        OP_STOP: begin
          if (state_r == ST_RUN) begin
            state_nxt_s = ST_PAUSE;
          end else begin
            state_nxt_s = state_r;
          end
        end
        OP_CLEAR: begin
          state_nxt_s = ST_IDLE;
          count_nxt_s = 8'd0;
`ifdef CNT_SEQ_PRESCALE_EN
          presc_restart_s = 1'b1;
`endif
        end
        default: begin
          state_nxt_s = state_r;
        end
      endcase
    end else if (tick_s) begin
      if (terminal_s) begin
        done_nxt_s = 1'b1;
        if (auto_reload_r) begin
          count_nxt_s = down_r ? limit_r : 8'd0;
`ifdef CNT_SEQ_PRESCALE_EN
          presc_restart_s = 1'b1;
`endif
        end else begin
          state_nxt_s = ST_DONE;
        end
      end else begin
        // Modulo-256 step; an up-count above the limit wraps through 0
        count_nxt_s = down_r ? (count_r - 8'd1) : (count_r + 8'd1);
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Architectural state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limit_r       <= LIMIT_RST;
      auto_reload_r <= 1'b0;
      down_r        <= 1'b0;
      count_r       <= 8'd0;
      state_r       <= ST_IDLE;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      limit_r       <= limit_nxt_s;
      auto_reload_r <= auto_reload_nxt_s;
      down_r        <= down_nxt_s;
      count_r       <= count_nxt_s;
      state_r       <= state_nxt_s;
      done_r        <= done_nxt_s;
      busy_r        <= (state_nxt_s == ST_RUN);
    end
  end

  // cmd_ready drops for exactly one cycle after each accepted command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready_r <= 1'b1;
    end else begin
      cmd_ready_r <= ~accept_s;
    end
  end

`ifdef CNT_SEQ_PRESCALE_EN
  // Prescale divider: counts 0..P in RUN, restarts on START/resume/reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_r  <= 4'd0;
      prescaler_r <= 4'd0;
    end else begin
      if (prescale_load_s) begin
        prescale_r <= cmd_data[7:4];
      end else begin
        prescale_r <= prescale_r;
      end
      if (presc_restart_s || (tick_s && !accept_s)) begin
        prescaler_r <= 4'd0;
      end else if ((state_r == ST_RUN) && !accept_s) begin
        prescaler_r <= prescaler_r + 4'd1;
      end else begin
        prescaler_r <= prescaler_r;
      end
    end
  end
`endif

endmodule
